// File: rtl/sram_mem_arbiter_pkg.sv
// Shared types and constants for the SRAM request arbiter: FSM encoding,
// MIPS kseg0/kseg1 segment constants and transfer size encodings.
package sram_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] SEG_MASK   = 32'h1FFF_FFFF;

    // Top three address bits identify the 512 MB segment.
    localparam logic [2:0] KSEG0_SEG = KSEG0_BASE[31:29];
    localparam logic [2:0] KSEG1_SEG = KSEG1_BASE[31:29];

endpackage

// File: rtl/sram_mem_arbiter_seg_addr_map.sv
// Combinational MIPS virtual-to-physical map: kseg0 and kseg1 fold onto the
// low 512 MB; kseg1 is flagged uncached, everything else passes through.
module sram_mem_arbiter_seg_addr_map
    import sram_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] vaddr_i,
    output logic [AW-1:0] paddr_o,
    output logic          uncached_o
);

    logic [2:0] seg;
    assign seg = vaddr_i[AW-1 -: 3];

    always_comb begin
        paddr_o    = vaddr_i;
        uncached_o = 1'b0;
        if (seg == KSEG0_SEG) begin
            paddr_o = vaddr_i - AW'(KSEG0_BASE);
        end else if (seg == KSEG1_SEG) begin
            paddr_o    = vaddr_i & AW'(SEG_MASK);
            uncached_o = 1'b1;
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// N-channel SRAM-like request arbiter with one outstanding transaction,
// fixed-priority or round-robin grant, and kseg0/kseg1 address translation.
module sram_mem_arbiter
    import sram_mem_arbiter_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [2*NCH-1:0]      ch_size,
    input  logic [AW*NCH-1:0]     ch_addr,
    input  logic [DW*NCH-1:0]     ch_wdata,
    input  logic [(DW/8)*NCH-1:0] ch_wstrb,
    output logic [NCH-1:0]        ch_addr_ok,
    output logic [NCH-1:0]        ch_data_ok,
    output logic [DW-1:0]         ch_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_wstrb,
    output logic                  mem_uncached,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

    // Grant: lowest index in fixed mode, otherwise first requester after last.
    function automatic logic [GW-1:0] pick(input logic [NCH-1:0] req,
                                           input logic [GW-1:0]  last);
        logic [GW-1:0] g;
        logic          found;
        int unsigned   idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (RR_MODE != 0) idx = (32'(last) + 32'd1 + i) % NCH;
            else              idx = i;
            if (!found && req[GW'(idx)]) begin
                g     = GW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    logic [1:0]    size_a  [NCH];
    logic [AW-1:0] addr_a  [NCH];
    logic [DW-1:0] wdata_a [NCH];
    logic [SW-1:0] wstrb_a [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign size_a[c]  = ch_size[2*c +: 2];
        assign addr_a[c]  = ch_addr[AW*c +: AW];
        assign wdata_a[c] = ch_wdata[DW*c +: DW];
        assign wstrb_a[c] = ch_wstrb[SW*c +: SW];
    end

    state_e        state_q,   state_d;
    logic [GW-1:0] grant_q,   grant_d;
    logic [GW-1:0] last_q,    last_d;
    logic          wr_q,      wr_d;
    size_e         size_q,    size_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [SW-1:0] wstrb_q,   wstrb_d;
    logic          unc_q,     unc_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [NCH-1:0] data_ok_q, data_ok_d;
    logic [NCH-1:0] addr_ok_c;

    logic [GW-1:0] sel;
    logic [AW-1:0] sel_paddr;
    logic          sel_unc;

    assign sel = pick(ch_req, last_q);

    sram_mem_arbiter_seg_addr_map #(
        .AW (AW)
    ) u_seg_addr_map (
        .vaddr_i    (addr_a[sel]),
        .paddr_o    (sel_paddr),
        .uncached_o (sel_unc)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        unc_d     = unc_q;
        rdata_d   = rdata_q;
        data_ok_d = '0;
        addr_ok_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    addr_ok_c[sel] = 1'b1;
                    grant_d        = sel;
                    last_d         = sel;
                    wr_d           = ch_wr[sel];
                    size_d         = size_e'(size_a[sel]);
                    addr_d         = sel_paddr;
                    wdata_d        = wdata_a[sel];
                    wstrb_d        = wstrb_a[sel];
                    unc_d          = sel_unc;
                    state_d        = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        rdata_d            = mem_rdata;
                        data_ok_d[grant_q] = 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    rdata_d            = mem_rdata;
                    data_ok_d[grant_q] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NCH - 1);
            wr_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            unc_q     <= 1'b0;
            rdata_q   <= '0;
            data_ok_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            unc_q     <= unc_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
        end
    end

    // Accept pulse is the only combinational output; silence it during reset.
    assign ch_addr_ok   = addr_ok_c & {NCH{resetn}};
    assign ch_data_ok   = data_ok_q;
    assign ch_rdata     = rdata_q;
    assign mem_req      = (state_q == ST_REQ);
    assign mem_wr       = wr_q;
    assign mem_size     = size_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign mem_uncached = unc_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Scoreboard bench for sram_mem_arbiter: a round-robin and a fixed-priority
// instance share stimulus; completions are checked by a separate monitor.
module tb_sram_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic [1:0]  ch_req;
    logic [1:0]  ch_wr;
    logic [3:0]  ch_size;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [7:0]  ch_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic [1:0]  rr_ch_addr_ok, rr_ch_data_ok, fp_ch_addr_ok, fp_ch_data_ok;
    logic [31:0] rr_ch_rdata, fp_ch_rdata;
    logic        rr_mem_req, rr_mem_wr, rr_mem_uncached;
    logic        fp_mem_req, fp_mem_wr, fp_mem_uncached;
    logic [1:0]  rr_mem_size, fp_mem_size;
    logic [31:0] rr_mem_addr, rr_mem_wdata, fp_mem_addr, fp_mem_wdata;
    logic [3:0]  rr_mem_wstrb, fp_mem_wstrb;

    sram_mem_arbiter #(.NCH(2), .AW(32), .DW(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_addr_ok(rr_ch_addr_ok), .ch_data_ok(rr_ch_data_ok), .ch_rdata(rr_ch_rdata),
        .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_size(rr_mem_size),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wstrb(rr_mem_wstrb),
        .mem_uncached(rr_mem_uncached),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    sram_mem_arbiter #(.NCH(2), .AW(32), .DW(32), .RR_MODE(0)) dut_fp (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_addr_ok(fp_ch_addr_ok), .ch_data_ok(fp_ch_data_ok), .ch_rdata(fp_ch_rdata),
        .mem_req(fp_mem_req), .mem_wr(fp_mem_wr), .mem_size(fp_mem_size),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb),
        .mem_uncached(fp_mem_uncached),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int unsigned ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rr_zero"}, 128'({rr_ch_addr_ok, rr_ch_data_ok, rr_ch_rdata, rr_mem_req,
            rr_mem_wr, rr_mem_size, rr_mem_addr, rr_mem_wdata, rr_mem_wstrb, rr_mem_uncached}), '0);
        chk({tag, "_fp_zero"}, 128'({fp_ch_addr_ok, fp_ch_data_ok, fp_ch_rdata, fp_mem_req,
            fp_mem_wr, fp_mem_size, fp_mem_addr, fp_mem_wdata, fp_mem_wstrb, fp_mem_uncached}), '0);
    endtask

    // Completion monitor for the round-robin instance.
    always @(negedge clk) begin
        if (resetn && rr_ch_data_ok != 2'b00) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_data_ok", 128'(rr_ch_data_ok), '0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_data_ok", 128'(rr_ch_data_ok), 128'(2'b01 << mon_e.ch));
                chk("sb_rdata", 128'(rr_ch_rdata), 128'(mon_e.data));
            end
        end
    end

    initial begin
        int unsigned g;
        logic [31:0] rd;
        resetn = 1'b0; ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0;
        ch_wdata = '0; ch_wstrb = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;

        // Uncached kseg1 read, zero-latency memory
        tick; ch_req = 2'b01; ch_wr = 2'b00; ch_size[1:0] = 2'd2; ch_addr[31:0] = 32'hBFC0_0000;
        @(negedge clk);
        chk("rd_addr_ok", 128'(rr_ch_addr_ok), 128'(2'b01));
        sb_q.push_back('{0, 32'h1234_5678});
        tick; ch_req = 2'b00; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_mem_req", 128'(rr_mem_req), 128'(1'b1));
        chk("rd_mem_addr", 128'(rr_mem_addr), 128'(32'h1FC0_0000));
        chk("rd_uncached", 128'(rr_mem_uncached), 128'(1'b1));
        tick; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("rd_data_ok_lat", 128'(rr_ch_data_ok), 128'(2'b01));
        chk("rd_mem_req_drop", 128'(rr_mem_req), 128'(1'b0));

        // Both channels requesting continuously; round-robin last grant is ch0
        ch_addr[31:0] = 32'h0000_1000; ch_addr[63:32] = 32'h8000_2000;
        for (int i = 0; i < 4; i++) begin
            g  = (i + 1) % 2;
            rd = 32'h5000_0000 + 32'(i);
            tick; ch_req = 2'b11; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = rd;
            @(negedge clk);
            chk("rr_grant", 128'(rr_ch_addr_ok), 128'(2'b01 << g));
            chk("fp_grant", 128'(fp_ch_addr_ok), 128'(2'b01));
            if (i > 0) begin
                chk("fp_data_ok", 128'(fp_ch_data_ok), 128'(2'b01));
                chk("fp_rdata", 128'(fp_ch_rdata), 128'(rd - 32'd1));
            end
            sb_q.push_back('{g, rd});
            tick;
            @(negedge clk);
            chk("rr_mem_addr", 128'(rr_mem_addr), (g == 1) ? 128'(32'h0000_2000) : 128'(32'h0000_1000));
            chk("fp_mem_addr", 128'({fp_mem_req, fp_mem_addr}), 128'({1'b1, 32'h0000_1000}));
        end
        tick; ch_req = 2'b00; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        @(negedge clk);
        chk("fp_last_data_ok", 128'({fp_ch_data_ok, fp_ch_rdata}), 128'({2'b01, 32'h5000_0003}));

        // Half-word write on ch1 into kseg0 with a 3-cycle addr_ok stall
        tick; ch_req = 2'b10; ch_wr = 2'b10; ch_size[3:2] = 2'd1; ch_addr[63:32] = 32'h8000_0100;
        ch_wdata[63:32] = 32'hDEAD_BEEF; ch_wstrb[7:4] = 4'h3;
        @(negedge clk);
        chk("wr_addr_ok", 128'(rr_ch_addr_ok), 128'(2'b10));
        chk("wr_addr_ok_fp", 128'(fp_ch_addr_ok), 128'(2'b10));
        sb_q.push_back('{1, 32'h0BAD_F00D});
        tick; ch_req = 2'b00;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) mem_addr_ok = 1'b1;
            @(negedge clk);
            chk("wr_fields", 128'({rr_mem_req, rr_mem_wr, rr_mem_uncached, rr_mem_size,
                rr_mem_wstrb, rr_mem_addr, rr_mem_wdata}),
                128'({1'b1, 1'b1, 1'b0, 2'd1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF}));
            chk("wr_no_data_ok", 128'(rr_ch_data_ok), '0);
            tick;
        end
        mem_addr_ok = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("wait_quiet", 128'({rr_mem_req, rr_ch_data_ok}), '0);
            tick;
        end
        mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("wr_before_data_ok", 128'(rr_ch_data_ok), '0);
        tick; mem_data_ok = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("wr_data_ok", 128'(rr_ch_data_ok), 128'(2'b10));

        // Spurious mem_data_ok while idle
        tick; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick; mem_data_ok = 1'b0;
        @(negedge clk);
        chk("spur_data_ok", 128'({rr_ch_data_ok, fp_ch_data_ok}), '0);
        chk("spur_rdata", 128'(rr_ch_rdata), 128'(32'h0BAD_F00D));

        // Reset while waiting for read data
        tick; ch_req = 2'b01; ch_wr = 2'b00; ch_addr[31:0] = 32'h0000_0040;
        @(negedge clk);
        chk("rst_pre_grant", 128'(rr_ch_addr_ok), 128'(2'b01));
        tick; ch_req = 2'b00; mem_addr_ok = 1'b1;
        tick; mem_addr_ok = 1'b0;
        @(negedge clk);
        chk("rst_in_wait", 128'(rr_mem_req), 128'(1'b0));
        tick; resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        resetn = 1'b1;
        tick; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        tick; mem_data_ok = 1'b0;
        @(negedge clk);
        chk("rst_no_data_ok", 128'({rr_ch_data_ok, fp_ch_data_ok}), '0);
        chk("rst_rdata", 128'(rr_ch_rdata), '0);
        tick; ch_req = 2'b11; ch_addr[63:32] = 32'h9000_0004;
        @(negedge clk);
        chk("post_rst_grant", 128'(rr_ch_addr_ok), 128'(2'b01));
        sb_q.push_back('{0, 32'h7777_7777});
        tick; ch_req = 2'b00; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("post_rst_addr", 128'({rr_mem_uncached, rr_mem_addr}), 128'({1'b0, 32'h0000_0040}));
        tick; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        @(negedge clk);
        tick;
        chk("sb_drained", 128'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_mem_arbiter.md
# sram_mem_arbiter

Parametrised N-channel SRAM-like request arbiter with built-in MIPS segment address translation. It sits between the CPU core's instruction/data request ports (and any future masters) and one shared memory port. It serialises requests with fixed-priority or round-robin grant and keeps one transaction outstanding. It also maps kseg0/kseg1 virtual addresses to physical addresses and flags uncached accesses.

## Interface
- NCH, 2, number of requesting channels (1..8); channel 0 = instruction, 1 = data
- AW, 32, address width
- DW, 32, data width (wstrb width DW/8)
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- ch_req  in  NCH  per-channel request, held until ch_addr_ok
- ch_wr  in  NCH  1 = write
- ch_size  in  2*NCH  0 = byte, 1 = half, 2 = word
- ch_addr  in  AW*NCH  virtual address
- ch_wdata  in  DW*NCH  write data
- ch_wstrb  in  (DW/8)*NCH  byte enables
- ch_addr_ok  out  NCH  request accepted (one-cycle pulse)
- ch_data_ok  out  NCH  transaction complete (one-cycle pulse)
- ch_rdata  out  DW  read data, valid with ch_data_ok
- mem_req, mem_wr  out  1  memory request / write
- mem_size  out  2;  mem_addr  out  AW physical;  mem_wdata  out  DW;  mem_wstrb  out  DW/8
- mem_uncached  out  1  address fell in kseg1
- mem_addr_ok, mem_data_ok  in  1  memory handshake;  mem_rdata  in  DW

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: if any ch_req, select grant g. Pulse ch_addr_ok[g] combinationally in the same cycle. Latch g and the channel's wr/size/translated addr/wdata/wstrb/uncached into registers. Go to REQ.
- REQ: drive mem_req=1 and the latched fields.
  - mem_addr_ok=1 → WAIT.
  - mem_addr_ok=1 with mem_data_ok=1 in the same cycle → complete immediately (see below) → IDLE.
- WAIT: mem_req=0. On mem_data_ok: register mem_rdata into ch_rdata, set ch_data_ok[g]=1 for the following cycle, → IDLE.
- Writes complete through mem_data_ok exactly like reads.
- mem_data_ok outside REQ/WAIT is ignored.
- Grant:
  - Fixed mode: lowest asserted index.
  - Round-robin: search starts at last_grant+1 modulo NCH. last_grant updates only on grant.
- Translation:
  - 0x8000_0000–0x9FFF_FFFF → addr−0x8000_0000, cached.
  - 0xA000_0000–0xBFFF_FFFF → addr & 0x1FFF_FFFF, uncached.
  - All other addresses pass through, cached.
- A channel dropping ch_req before grant is legal; it is simply not granted.
- Reset (any time, including mid-transaction) → IDLE.
  - All outputs 0, ch_rdata 0.
  - last_grant = NCH−1, so channel 0 wins the first round-robin arbitration.
  - The aborted transaction is not reported.

## Timing
- ch_req to ch_addr_ok: 0 cycles when IDLE.
- ch_addr_ok to mem_req: 1 cycle.
- mem_data_ok to ch_data_ok/ch_rdata: 1 cycle (registered).
- Minimum transaction: IDLE, REQ (addr_ok and data_ok together), then ch_data_ok. A new grant may occur in the same IDLE cycle that ch_data_ok is high.
- Back-to-back throughput: one transaction per 2 cycles minimum.
- mem_addr_ok stalls hold REQ with stable fields indefinitely. No timeout.
- ch_addr_ok is never asserted for more than one channel per cycle.

## Structure
- Shared package: FSM state encoding, KSEG0_BASE, KSEG1_BASE, SEG_MASK constants, size encodings.
- Sub-module seg_addr_map: combinational virtual→physical map plus uncached flag. One instance, on the selected channel address before latching.
- Arbiter grant logic is a function inside the top module.

## Test plan
- Single read on ch0, addr 0xBFC0_0000; memory returns 0x1234_5678 with addr_ok/data_ok both on the first REQ cycle → mem_addr 0x1FC0_0000, mem_uncached=1; ch_data_ok[0] one cycle later with ch_rdata 0x1234_5678.
- ch0 and ch1 requesting continuously, RR_MODE=1 → grants alternate 0,1,0,1.
- Same stimulus with RR_MODE=0 → ch0 always wins and ch1 starves.
- Write on ch1 to 0x8000_0100, wstrb 0x3, mem_addr_ok delayed 3 cycles → mem_addr 0x0000_0100, mem_uncached=0; mem fields stable through the 3 stall cycles; ch_data_ok[1] only after mem_data_ok.
- resetn deasserted while in WAIT → all outputs 0 immediately; a later mem_data_ok produces no ch_data_ok; the first request after reset is granted normally.
- Spurious mem_data_ok in IDLE → no ch_data_ok, ch_rdata unchanged.
